// File: rtl/disp_mux_n_if.sv
// -----------------------------------------------------------------------------
// disp_mux_n_if
// Bundle between the display-formatting logic and the seven-segment scan
// driver.
//   digits     : segment pattern of digit i at [8i+7:8i], dp in bit 7,
//                already in output polarity
//   dig_en     : per-digit enable
//   bright     : 4-bit brightness, 0 = off, 15 = full on
//   an         : anode enables (one-hot active or all inactive)
//   sseg       : segment drive
//   slot       : current scan slot index
//   frame_tick : one-cycle pulse when the scan wraps back to slot 0
// master = formatting side, slave = driver side.
// -----------------------------------------------------------------------------
interface disp_mux_n_if #(
    parameter int NUM_DIG = 8
);
    localparam int SLOT_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

    logic [8*NUM_DIG-1:0] digits;
    logic [NUM_DIG-1:0]   dig_en;
    logic [3:0]           bright;
    logic [NUM_DIG-1:0]   an;
    logic [7:0]           sseg;
    logic [SLOT_W-1:0]    slot;
    logic                 frame_tick;

    modport master (
        output digits, dig_en, bright,
        input  an, sseg, slot, frame_tick
    );

    modport slave (
        input  digits, dig_en, bright,
        output an, sseg, slot, frame_tick
    );
endinterface

// File: rtl/disp_mux_n.sv
// -----------------------------------------------------------------------------
// disp_mux_n
// Time-multiplexed driver for NUM_DIG common-anode seven-segment digits.
// Each digit owns a slot of TICK_DIV cycles; the first BLANK_CYC cycles of
// every slot keep all anodes off (anti-ghosting dead-time), and a free-running
// 4-bit PWM counter dims the display to bright/16 duty.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : disp_mux_n_if.slave (digits, dig_en, bright in; an, sseg, slot,
//           frame_tick out)
// an/sseg are registered and lag the (cnt, slot) state by one cycle;
// slot and frame_tick do not lag.
// -----------------------------------------------------------------------------
module disp_mux_n #(
    parameter int NUM_DIG     = 8,
    parameter int TICK_DIV    = 6250,
    parameter int BLANK_CYC   = 64,
    parameter bit AN_ACT_LOW  = 1'b1,
    parameter bit SEG_ACT_LOW = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    disp_mux_n_if.slave  bus
);
    localparam int                SLOT_W   = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam int                CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TICK_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(NUM_DIG - 1);
    // XOR masks: an inactive anode / dark segment pattern in output polarity.
    localparam logic [NUM_DIG-1:0] AN_OFF  = {NUM_DIG{AN_ACT_LOW}};
    localparam logic [7:0]         SEG_OFF = {8{SEG_ACT_LOW}};

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [3:0]         pwm_q, pwm_d;
    logic               en_l_q, en_l_d;
    logic [3:0]         br_l_q, br_l_d;
    logic               tick_q, tick_d;
    logic [NUM_DIG-1:0] an_q, an_d;
    logic [7:0]         sseg_q, sseg_d;

    logic               cnt_wrap;
    logic               slot_wrap;
    logic [SLOT_W-1:0]  slot_next;
    logic               past_blank;
    logic               act;
    logic [NUM_DIG-1:0] onehot;

    // With no dead-time the blanking compare would be constant, so it is
    // elaborated away instead of comparing against zero.
    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign past_blank = 1'b1;
        end else begin : g_blank
            assign past_blank = (cnt_q >= CNT_W'(BLANK_CYC));
        end
    endgenerate

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        cnt_wrap  = (cnt_q == CNT_MAX);
        slot_wrap = (slot_q == SLOT_MAX);
        // Explicit wrap at NUM_DIG-1 so non-power-of-2 digit counts never alias.
        slot_next = slot_wrap ? '0 : slot_q + 1'b1;

        cnt_d  = cnt_wrap ? '0 : cnt_q + 1'b1;
        slot_d = cnt_wrap ? slot_next : slot_q;
        pwm_d  = pwm_q + 4'd1;
        en_l_d = en_l_q;
        br_l_d = br_l_q;
        // Enable and brightness are sampled only at the slot boundary so a
        // digit never changes state mid-slot.
        if (cnt_wrap) begin
            en_l_d = bus.dig_en[slot_next];
            br_l_d = bus.bright;
        end

        act = en_l_q && past_blank && ((br_l_q == 4'hF) || (pwm_q < br_l_q));

        onehot = '0;
        if (act) begin
            onehot[slot_q] = 1'b1;
        end
        an_d   = onehot ^ AN_OFF;
        // Segments are forced dark whenever the anode is off: no stale pattern.
        sseg_d = act ? bus.digits[{slot_q, 3'b000} +: 8] : SEG_OFF;
        tick_d = cnt_wrap && slot_wrap;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            slot_q <= '0;
            pwm_q  <= '0;
            en_l_q <= 1'b0;
            br_l_q <= '0;
            tick_q <= 1'b0;
            an_q   <= AN_OFF;
            sseg_q <= SEG_OFF;
        end else begin
            cnt_q  <= cnt_d;
            slot_q <= slot_d;
            pwm_q  <= pwm_d;
            en_l_q <= en_l_d;
            br_l_q <= br_l_d;
            tick_q <= tick_d;
            an_q   <= an_d;
            sseg_q <= sseg_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.sseg       = sseg_q;
    assign bus.slot       = slot_q;
    assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_disp_mux_n.sv
// -----------------------------------------------------------------------------
// tb_disp_mux_n
// Directed bench for disp_mux_n with three instances:
//   u_a : NUM_DIG=4, TICK_DIV=8,  BLANK_CYC=2 (scan, enables, brightness,
//         mid-slot change, async reset)
//   u_b : NUM_DIG=4, TICK_DIV=64, BLANK_CYC=0, bright=8 (PWM duty)
//   u_c : NUM_DIG=3, TICK_DIV=8,  BLANK_CYC=2 (non-power-of-2 scan)
// Frame offset j counts cycles from the negedge where frame_tick is seen
// (state slot 0, cnt 0); outputs at offset j reflect the state at j-1.
// -----------------------------------------------------------------------------
module tb_disp_mux_n;
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_bc = 1'b1;

    int n_checks = 0;
    int n_fail = 0;

    disp_mux_n_if #(.NUM_DIG(4)) bus_a ();
    disp_mux_n_if #(.NUM_DIG(4)) bus_b ();
    disp_mux_n_if #(.NUM_DIG(3)) bus_c ();

    disp_mux_n #(.NUM_DIG(4), .TICK_DIV(8), .BLANK_CYC(2),
                 .AN_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b1))
        u_a (.clk(clk), .reset(rst_a), .bus(bus_a));

    disp_mux_n #(.NUM_DIG(4), .TICK_DIV(64), .BLANK_CYC(0),
                 .AN_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b1))
        u_b (.clk(clk), .reset(rst_bc), .bus(bus_b));

    disp_mux_n #(.NUM_DIG(3), .TICK_DIV(8), .BLANK_CYC(2),
                 .AN_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b1))
        u_c (.clk(clk), .reset(rst_bc), .bus(bus_c));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance until the selected instance shows frame_tick, bounded.
    task automatic wait_tick(input int which, input int limit);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            case (which)
                0:       seen = bus_a.frame_tick;
                1:       seen = bus_b.frame_tick;
                default: seen = bus_c.frame_tick;
            endcase
        end
        check("tick_wait", {31'd0, seen}, 32'd1);
    endtask

    task automatic settle_a();
        wait_tick(0, 80);
        wait_tick(0, 80);
    endtask

    // One full frame of u_a against the scan pattern for a given enable mask
    // (bright assumed 15, or mask 0 for a dark display).
    task automatic check_frame_a(input logic [3:0] mask, input string tag);
        int p, pc, ps;
        logic act;
        logic [3:0] e_an;
        logic [7:0] e_seg;
        wait_tick(0, 80);
        for (int j = 0; j < 32; j++) begin
            if (j > 0) @(negedge clk);
            p  = (j + 31) % 32;
            pc = p % 8;
            ps = p / 8;
            act = mask[ps] && (pc >= 2);
            e_an = 4'hF;
            if (act) e_an[ps] = 1'b0;
            e_seg = act ? (8'hA0 + 8'(ps)) : 8'hFF;
            check($sformatf("%s_an_j%0d", tag, j), {28'd0, bus_a.an}, {28'd0, e_an});
            check($sformatf("%s_sseg_j%0d", tag, j), {24'd0, bus_a.sseg}, {24'd0, e_seg});
            check($sformatf("%s_slot_j%0d", tag, j), {30'd0, bus_a.slot}, 32'(j / 8));
            check($sformatf("%s_tick_j%0d", tag, j), {31'd0, bus_a.frame_tick}, {31'd0, (j == 0)});
        end
    endtask

    // First frame after reset release on u_a (called at the release negedge).
    task automatic check_restart_a(input string tag);
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            check($sformatf("%s_slot_k%0d", tag, k), {30'd0, bus_a.slot}, 32'((k / 8) % 4));
            check($sformatf("%s_tick_k%0d", tag, k), {31'd0, bus_a.frame_tick}, {31'd0, (k == 32)});
            if (k <= 10) begin
                check($sformatf("%s_dark_an_k%0d", tag, k), {28'd0, bus_a.an}, 32'hF);
                check($sformatf("%s_dark_sseg_k%0d", tag, k), {24'd0, bus_a.sseg}, 32'hFF);
            end
            if (k == 11) begin
                check($sformatf("%s_first_an", tag), {28'd0, bus_a.an}, 32'hD);
                check($sformatf("%s_first_sseg", tag), {24'd0, bus_a.sseg}, 32'hA1);
            end
        end
    endtask

    initial begin
        int cnt_d [4];
        int bad;
        int p, pc, ps;
        logic [2:0] e_an3;
        logic [3:0] pat;

        bus_a.digits = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        bus_a.dig_en = 4'hF;
        bus_a.bright = 4'd15;
        bus_b.digits = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
        bus_b.dig_en = 4'hF;
        bus_b.bright = 4'd8;
        bus_c.digits = {8'hC2, 8'hC1, 8'hC0};
        bus_c.dig_en = 3'b111;
        bus_c.bright = 4'd15;

        // Reset state while reset is held with the clock running.
        repeat (3) @(negedge clk);
        check("rst_an", {28'd0, bus_a.an}, 32'hF);
        check("rst_sseg", {24'd0, bus_a.sseg}, 32'hFF);
        check("rst_slot", {30'd0, bus_a.slot}, 32'd0);
        check("rst_tick", {31'd0, bus_a.frame_tick}, 32'd0);
        check("rst_c_an", {29'd0, bus_c.an}, 32'h7);
        rst_a = 1'b0;
        rst_bc = 1'b0;
        check_restart_a("start");

        // Scan order, full enable.
        settle_a();
        check_frame_a(4'hF, "scan");

        // Digit 2 disabled.
        bus_a.dig_en = 4'b1011;
        settle_a();
        check_frame_a(4'b1011, "en1011");

        // Brightness 0: permanently dark.
        bus_a.dig_en = 4'hF;
        bus_a.bright = 4'd0;
        settle_a();
        check_frame_a(4'h0, "br0");

        // digits is not latched: a change shows up on sseg one cycle later.
        bus_a.bright = 4'd15;
        settle_a();
        repeat (12) @(negedge clk);
        bus_a.digits = {8'hA3, 8'hA2, 8'h5A, 8'hA0};
        @(negedge clk);
        check("live_digit_an", {28'd0, bus_a.an}, 32'hD);
        check("live_digit_sseg", {24'd0, bus_a.sseg}, 32'h5A);
        bus_a.digits = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

        // Mid-slot change at slot 1, cnt 3.
        settle_a();
        repeat (11) @(negedge clk);
        bus_a.bright = 4'd0;
        bus_a.dig_en = 4'h0;
        for (int j = 12; j < 64; j++) begin
            @(negedge clk);
            if (j <= 16) begin
                check($sformatf("mid_on_an_j%0d", j), {28'd0, bus_a.an}, 32'hD);
                check($sformatf("mid_on_sseg_j%0d", j), {24'd0, bus_a.sseg}, 32'hA1);
            end else begin
                check($sformatf("mid_off_an_j%0d", j), {28'd0, bus_a.an}, 32'hF);
                check($sformatf("mid_off_sseg_j%0d", j), {24'd0, bus_a.sseg}, 32'hFF);
            end
        end

        // Asynchronous reset at slot 2, cnt 5, between clock edges.
        bus_a.bright = 4'd15;
        bus_a.dig_en = 4'hF;
        settle_a();
        repeat (21) @(negedge clk);
        check("prerst_an", {28'd0, bus_a.an}, 32'hB);
        check("prerst_slot", {30'd0, bus_a.slot}, 32'd2);
        #2;
        rst_a = 1'b1;
        #1;
        check("async_rst_an", {28'd0, bus_a.an}, 32'hF);
        check("async_rst_sseg", {24'd0, bus_a.sseg}, 32'hFF);
        check("async_rst_slot", {30'd0, bus_a.slot}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        check_restart_a("rerun");

        // Non-power-of-2 scan on u_c.
        wait_tick(2, 80);
        for (int j = 0; j < 24; j++) begin
            if (j > 0) @(negedge clk);
            p  = (j + 23) % 24;
            pc = p % 8;
            ps = p / 8;
            e_an3 = 3'b111;
            if (pc >= 2) e_an3[ps] = 1'b0;
            check($sformatf("n3_slot_j%0d", j), {30'd0, bus_c.slot}, 32'(j / 8));
            check($sformatf("n3_an_j%0d", j), {29'd0, bus_c.an}, {29'd0, e_an3});
            check($sformatf("n3_tick_j%0d", j), {31'd0, bus_c.frame_tick}, {31'd0, (j == 0)});
        end
        @(negedge clk);
        check("n3_tick_period", {31'd0, bus_c.frame_tick}, 32'd1);
        check("n3_slot_wrap", {30'd0, bus_c.slot}, 32'd0);

        // PWM duty on u_b: bright=8 over a 64-cycle unblanked slot.
        wait_tick(1, 600);
        @(negedge clk);
        for (int d = 0; d < 4; d++) cnt_d[d] = 0;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            pat = bus_b.an;
            case (pat)
                4'b1110: cnt_d[0]++;
                4'b1101: cnt_d[1]++;
                4'b1011: cnt_d[2]++;
                4'b0111: cnt_d[3]++;
                4'b1111: ;
                default: bad++;
            endcase
            @(negedge clk);
        end
        for (int d = 0; d < 4; d++) begin
            check($sformatf("pwm_active_d%0d", d), 32'(cnt_d[d]), 32'd32);
        end
        check("pwm_bad_pattern", 32'(bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/disp_mux_n.md
# disp_mux_n

Parametrised time-multiplexed LED display driver for any number of common-anode seven-segment digits. It scans `NUM_DIG` digits with a programmable slot period and per-digit enables. It adds inter-digit dead-time to suppress ghosting, and 16-level PWM brightness. It sits between the display-formatting logic (hex/BCD-to-segment encoders) and the board pins.

## Interface
Parameters:
- `NUM_DIG`, 8: number of digits scanned; 2..16, need not be a power of 2.
- `TICK_DIV`, 6250: clock cycles per digit slot (50 MHz / 8 / 6250 = 1 kHz per digit).
- `BLANK_CYC`, 64: dead-time cycles at the start of each slot with all anodes off; 0 ≤ `BLANK_CYC` < `TICK_DIV`.
- `AN_ACT_LOW`, 1: 1 means the anode enable is active-low.
- `SEG_ACT_LOW`, 1: 1 means segments are active-low; this sets the "all segments off" value.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `digits`  in  8*NUM_DIG  segment pattern for digit i at [8i+7:8i] (dp in bit 7), already in output polarity.
- `dig_en`  in  NUM_DIG  per-digit enable; a disabled digit stays dark during its slot.
- `bright`  in  4  brightness; 0 = off, 15 = full on.
- `an`  out  NUM_DIG  anode enables, one-hot active or all inactive.
- `sseg`  out  8  segment drive.
- `slot`  out  $clog2(NUM_DIG)  current slot index (the counter register).
- `frame_tick`  out  1  one-cycle pulse when the scan wraps to slot 0.

## Operation
- `cnt` is a prescaler. It counts 0..TICK_DIV-1 and then wraps to 0.
  - On a wrap, `slot` advances by 1, modulo NUM_DIG (explicit NUM_DIG-1 → 0; no power-of-2 aliasing).
- Slot-start latch: on the cycle where cnt == TICK_DIV-1, `en_l` <= dig_en[next slot] and `br_l` <= bright.
  - `dig_en` and `bright` changes take effect only at the next slot boundary, never mid-slot.
- `pwm` is a free-running 4-bit counter that increments every cycle and is unrelated to `cnt`.
- Active condition, evaluated every cycle: act = en_l AND cnt ≥ BLANK_CYC AND (br_l == 15 OR pwm < br_l).
- Registered outputs, updated every cycle:
  - Internal one-hot vector = act ? (1 << slot) : 0.
  - `an` = the vector, inverted if AN_ACT_LOW.
  - `sseg` = act ? digits[slot] : OFF, where OFF = 8'hFF if SEG_ACT_LOW, else 8'h00.
- When `an` is inactive, `sseg` is always OFF, with no stale pattern.
- `frame_tick` is registered. It is 1 for exactly one cycle, the same cycle `slot` becomes 0 after NUM_DIG-1.
- Reset values:
  - cnt = 0, slot = 0, pwm = 0, en_l = 0, br_l = 0, frame_tick = 0.
  - `an` all inactive; `sseg` = OFF.
- Reset asserted mid-frame forces these values immediately, asynchronously. Scanning restarts at slot 0, cnt 0, on the first clock after release.
- Because en_l = 0 out of reset, slot 0 of the first frame is dark. Normal display starts at slot 1.

## Timing
- `an`/`sseg` lag the (cnt, slot) state by one cycle. `slot` and `frame_tick` have no such lag.
- Frame period = NUM_DIG × TICK_DIV cycles. `frame_tick` period is identical.
- Per enabled slot at bright = 15:
  - Anode active for TICK_DIV − BLANK_CYC cycles.
  - The active run starts 1 cycle after cnt reaches BLANK_CYC and ends 1 cycle after cnt wraps.
- At bright = b (1..14), the anode is active in the cycles where pwm < b within the non-blanked window. This is b/16 duty, exact when the window is a multiple of 16.
- `digits` is not latched: an input change is visible on `sseg` one cycle later if the digit is active.
- There is no handshake, and no back-pressure exists.

## Test plan
Unless stated, use NUM_DIG=4, TICK_DIV=8, BLANK_CYC=2, both polarities active-low.

1. Reset and first frame:
   - Stimulus: hold reset, then release; dig_en=4'hF, bright=15.
   - Response: during reset an=4'hF, sseg=8'hFF, slot=0, frame_tick=0. Slot 0 of frame 1 stays an=4'hF.
2. Scan order:
   - Stimulus: digits={8'hA3,8'hA2,8'hA1,8'hA0}, dig_en=4'hF, bright=15.
   - Response: from frame 2 on, an=1110/1101/1011/0111 each for 6 consecutive cycles, separated by 2 cycles of 1111. sseg matches A0..A3 while active, FF otherwise. frame_tick is 1 once every 32 cycles, coincident with slot→0.
3. Enable and brightness:
   - Stimulus: dig_en=4'b1011.
   - Response: an=1011 never appears; slot 2 is all 1111 and sseg=FF.
   - Stimulus: bright=0.
   - Response: an=4'hF permanently.
   - Stimulus: TICK_DIV=64, BLANK_CYC=0, bright=8.
   - Response: exactly 32 active cycles per slot.
4. Mid-slot change:
   - Stimulus: bright 15→0 and dig_en 4'hF→4'h0 at cnt=3 of slot 1.
   - Response: slot 1 stays active through cnt=7; slot 2 onward is dark.
5. Reset mid-frame:
   - Stimulus: assert reset asynchronously at slot 2, cnt 5, between clock edges.
   - Response: an=4'hF and sseg=FF without waiting for a clock edge. After release, slot=0 and the scan restarts.
6. Non-power-of-2 count:
   - Stimulus: NUM_DIG=3.
   - Response: slot sequence 0,1,2,0,… with no slot 3. an is only 3'b110/101/011/111. frame_tick period is 24 cycles.
